// File: rtl/pipe_pkg.sv
// Playfield geometry, column/frame types and scroll FSM states, shared by the
// scroll controller and its testbench.
package pipe_pkg;
  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef logic [ROWS-1:0] column_t;
  typedef column_t [COLS-1:0] frame_t;

  typedef enum logic [2:0] {IDLE, WAIT, REQ, LOAD, SHIFT} scroll_state_t;
endpackage

// File: rtl/tick_divider.sv
// Mod-TICK_DIV scroll-step counter. tick marks the terminal count while enabled;
// the count holds whenever en is low.
module tick_divider #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/pipe_scroll_ctrl.sv
// Scrolls pipe columns across the playfield framebuffer. pat_col is the pattern
// generator's unpacked output_data[0:15] packed as pat_col[r] = output_data[r].
module pipe_scroll_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 5_000_000,
  parameter int unsigned PIPE_WIDTH = 2,
  parameter int unsigned PIPE_GAP   = 4,
  parameter int unsigned BIRD_COL   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       clear,
  output logic                       pat_en,
  input  logic [ROWS-1:0]            pat_col,
  output logic [COLS-1:0][ROWS-1:0]  frame,
  output logic [ROWS-1:0]            bird_col,
  output logic                       shift_done,
  output logic [7:0]                 score,
  output logic                       busy
);
  localparam int unsigned PERIOD = PIPE_WIDTH + PIPE_GAP;
  localparam int unsigned SW = $clog2(PERIOD);
  localparam int unsigned CI = $clog2(COLS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(PERIOD - 1);
  localparam logic [SW-1:0] SLOT_PIPE = SW'(PIPE_WIDTH);
  localparam logic [CI-1:0] BIRD_IDX  = CI'(BIRD_COL);

  scroll_state_t state_reg;
  frame_t        frame_reg;
  frame_t        shifted;
  column_t       pat_hold_reg;
  column_t       new_col;
  logic [SW-1:0] slot_reg;
  logic [7:0]    score_reg;
  logic          pat_en_reg;
  logic          shift_done_reg;
  logic          busy_reg;
  logic          tick_en;
  logic          tick;
  logic          trailing_exit;

  assign tick_en = (state_reg == WAIT) && run && !clear;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .clr  (clear),
    .tick (tick)
  );

  assign new_col = (slot_reg < SLOT_PIPE) ? pat_hold_reg : '0;

  for (genvar gi = 0; gi < COLS - 1; gi++) begin : g_shift
    assign shifted[gi] = frame_reg[gi+1];
  end
  assign shifted[COLS-1] = new_col;

  // A pipe's last column is about to fall off the left edge.
  assign trailing_exit = (frame_reg[0] != '0) && (frame_reg[1] == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      frame_reg      <= '0;
      pat_hold_reg   <= '0;
      slot_reg       <= '0;
      score_reg      <= '0;
      pat_en_reg     <= 1'b0;
      shift_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      pat_en_reg     <= 1'b0;
      shift_done_reg <= 1'b0;
      if (clear) begin
        state_reg <= IDLE;
        frame_reg <= '0;
        slot_reg  <= '0;
        score_reg <= '0;
        busy_reg  <= 1'b0;
      end else begin
        unique case (state_reg)
          IDLE: if (run) state_reg <= WAIT;
          WAIT: begin
            if (!run) begin
              state_reg <= IDLE;
            end else if (tick) begin
              busy_reg <= 1'b1;
              if (slot_reg == '0) begin
                state_reg  <= REQ;
                pat_en_reg <= 1'b1;
              end else begin
                state_reg <= SHIFT;
              end
            end
          end
          REQ: state_reg <= LOAD;
          // The generator advanced on the REQ edge; capture its new pattern.
          LOAD: begin
            pat_hold_reg <= pat_col;
            state_reg    <= SHIFT;
          end
          SHIFT: begin
            frame_reg      <= shifted;
            slot_reg       <= (slot_reg == SLOT_LAST) ? '0 : slot_reg + SW'(1);
            if (trailing_exit && score_reg != 8'hFF) score_reg <= score_reg + 8'd1;
            shift_done_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= run ? WAIT : IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign frame      = frame_reg;
  assign bird_col   = frame_reg[BIRD_IDX];
  assign pat_en     = pat_en_reg;
  assign shift_done = shift_done_reg;
  assign score      = score_reg;
  assign busy       = busy_reg;
endmodule

// File: tb/tb_pipe_scroll_ctrl.sv
// Self-checking bench for pipe_scroll_ctrl: cycle table for the first pipe,
// hand-written corner sequences and a randomized run against a column-queue model.
module tb_pipe_scroll_ctrl;
  import pipe_pkg::*;

  localparam int TD = 4;
  localparam int PW = 2;
  localparam int PG = 2;
  localparam int BC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic clear = 1'b0;
  logic pat_en;
  logic shift_done;
  logic busy;
  logic [7:0] score;
  column_t pat_col;
  column_t bird_col;
  frame_t frame;

  logic gen_fixed = 1'b1;
  column_t gen_val = 16'h1234;

  pipe_scroll_ctrl #(
    .TICK_DIV(TD), .PIPE_WIDTH(PW), .PIPE_GAP(PG), .BIRD_COL(BC)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .pat_en(pat_en),
    .pat_col(pat_col), .frame(frame), .bird_col(bird_col),
    .shift_done(shift_done), .score(score), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pattern generator model: advances on every pat_en, never produces an empty column.
  assign pat_col = gen_val;
  always @(posedge clk) begin
    if (pat_en) begin
      if (gen_fixed) gen_val <= 16'hFF8F;
      else gen_val <= 16'($urandom_range(1, 16'hFFFF));
    end
  end

  // Reference model: playfield as a queue of columns, col 0 at the front.
  column_t m_cols[$];
  column_t m_pat;
  int m_pos, m_score;
  int n_pat, n_shift, cyc;
  int n_checks, n_pass;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_cols.delete();
    repeat (COLS) m_cols.push_back('0);
    m_pos = 0;
    m_score = 0;
  endfunction

  function automatic void model_shift();
    column_t leaving, nc;
    if (m_pos == 0) m_pat = gen_val;
    nc = (m_pos < PW) ? m_pat : '0;
    leaving = m_cols.pop_front();
    if (leaving != '0 && m_cols[0] == '0 && m_score < 255) m_score++;
    m_cols.push_back(nc);
    m_pos = (m_pos + 1) % (PW + PG);
  endfunction

  function automatic frame_t exp_frame();
    frame_t f;
    for (int c = 0; c < COLS; c++) f[c] = m_cols[c];
    return f;
  endfunction

  task automatic sample();
    if (reset || clear) begin
      model_reset();
    end else begin
      if (pat_en) begin
        n_pat++;
        check("pat_en_slot0", pat_en, m_pos == 0);
      end
      if (shift_done) begin
        n_shift++;
        model_shift();
      end
    end
    check("frame", frame, exp_frame());
    check("score", score, m_score);
    check("bird_col", bird_col, m_cols[BC]);
  endtask

  // One clock: outputs sampled 1 time unit after the edge, inputs changed 3 after.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    sample();
    #2;
  endtask

  task automatic wait_pat(output int edges);
    edges = 0;
    do begin step(); edges++; end while (pat_en !== 1'b1 && edges < 200);
    check("pat_en_seen", pat_en, 1'b1);
  endtask

  task automatic wait_shift(output int edges);
    edges = 0;
    do begin step(); edges++; end while (shift_done !== 1'b1 && edges < 200);
    check("shift_done_seen", shift_done, 1'b1);
  endtask

  typedef struct {
    logic run, clr, pe, bsy, sd;
    column_t c15, c14;
  } vec_t;

  function automatic vec_t mk(logic r, logic c, logic pe, logic b, logic sd,
                              column_t c15, column_t c14);
    vec_t v;
    v.run = r; v.clr = c; v.pe = pe; v.bsy = b; v.sd = sd; v.c15 = c15; v.c14 = c14;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t tbl[16];
    int e, t0, p0, s0, n, exp_sc, guard;

    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFF8F, 16'h0000);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFF8F, 16'h0000);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFF8F, 16'h0000);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFF8F, 16'h0000);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFF8F, 16'h0000);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFF8F, 16'hFF8F);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFF8F, 16'hFF8F);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFF8F, 16'hFF8F);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset state
    step(); step();
    reset = 1'b0;
    step();
    check("reset_pat_en", pat_en, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_shift_done", shift_done, 1'b0);
    check("reset_score", score, 8'd0);

    // First pipe, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      run = tbl[i].run;
      clear = tbl[i].clr;
      step();
      check($sformatf("tbl%0d_pat_en", i), pat_en, tbl[i].pe);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      check($sformatf("tbl%0d_shift_done", i), shift_done, tbl[i].sd);
      check($sformatf("tbl%0d_frame15", i), frame[15], tbl[i].c15);
      check($sformatf("tbl%0d_frame14", i), frame[14], tbl[i].c14);
    end
    clear = 1'b0;
    gen_fixed = 1'b0;

    // Cadence over 40 ticks, then score progression and saturation
    run = 1'b1;
    t0 = cyc; p0 = n_pat; s0 = n_shift; guard = 0;
    while (n_shift - s0 < 1220 && guard < 20000) begin
      step();
      guard++;
      if (shift_done) begin
        n = n_shift - s0;
        exp_sc = (n >= 18) ? ((n - 18) / 4 + 1) : 0;
        if (exp_sc > 255) exp_sc = 255;
        check("score_progress", score, exp_sc);
        if (n == 40) begin
          check("edges_to_40_shifts", cyc - t0, 221);
          check("pat_en_in_40_ticks", n_pat - p0, 10);
        end
      end
    end
    check("score_saturated", score, 8'd255);
    run = 1'b0; step();
    clear = 1'b1; step();
    clear = 1'b0;

    // Freeze: run dropped in the REQ cycle
    run = 1'b1;
    wait_pat(e);
    check("first_pat_edges", e, TD + 1);
    p0 = n_pat;
    run = 1'b0;
    step(); check("freeze_load_busy", busy, 1'b1);
    step(); check("freeze_shift_busy", busy, 1'b1);
    step(); check("freeze_shift_done", shift_done, 1'b1);
    s0 = n_shift;
    repeat (20) step();
    check("freeze_no_pat_en", n_pat - p0, 0);
    check("freeze_no_shift", n_shift - s0, 0);
    check("freeze_idle_busy", busy, 1'b0);

    // Tick count held across a freeze mid-WAIT
    run = 1'b1; step(); step(); step();
    run = 1'b0; repeat (10) step();
    run = 1'b1;
    wait_shift(e);
    check("resume_edges", e, 4);

    // Clear coincident with the terminal tick
    step(); step(); step();
    clear = 1'b1;
    step();
    check("clear_shift_done", shift_done, 1'b0);
    check("clear_pat_en", pat_en, 1'b0);
    check("clear_busy", busy, 1'b0);
    check("clear_frame", frame, '0);
    check("clear_score", score, 8'd0);
    clear = 1'b0;
    s0 = n_shift;
    wait_pat(e);
    check("clear_slot0_pat_edges", e, TD + 1);
    check("clear_no_shift_before_pat", n_shift - s0, 0);

    // Reset mid-LOAD with a populated frame and nonzero score
    for (int k = 0; k < 20; k++) wait_shift(e);
    wait_pat(e);
    step();
    check("pre_reset_busy", busy, 1'b1);
    check("pre_reset_score", score, 8'd1);
    reset = 1'b1;
    #1;
    check("rst_frame", frame, '0);
    check("rst_score", score, 8'd0);
    check("rst_pat_en", pat_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    step(); step();
    run = 1'b0;
    reset = 1'b0;
    repeat (5) step();
    check("post_reset_idle_busy", busy, 1'b0);
    run = 1'b1;
    wait_pat(e);
    check("post_reset_pat_edges", e, TD + 1);

    // Randomized run/clear against the model
    for (int k = 0; k < 3000; k++) begin
      run = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 199) == 0);
      step();
    end
    run = 1'b0;
    clear = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
